regfile_wb_queue: RTL
=====================

// Module: regfile_wb_queue
// PURPOSE
//  Write-back queue feeding the write port (we/wr_addr/wr_data) of the 4x8 register file.
//  Accepts results from the execute stage via valid/ready and buffers them in order in a
//  DEPTH-entry FIFO. Drains at most one entry per cycle into the register file.
//  Forwards pending (not yet written) values to the two register-file read ports, so readers
//  never see stale data.
// PARAMETERS
//  DATA_W  8  write data width; matches the register file word
//  ADDR_W  2  register address width (2**ADDR_W registers)
//  DEPTH   4  FIFO entries; power of two, >=2
// PORTS
//  clk         in   1                  rising-edge clock
//  rst_n       in   1                  asynchronous active-low reset
//  in_valid    in   1                  producer has a write-back result
//  in_ready    out  1                  queue can accept this cycle
//  in_addr     in   ADDR_W             destination register
//  in_data     in   DATA_W             result value
//  flush       in   1                  discard all pending entries (synchronous)
//  rf_hold     in   1                  register file write port unavailable this cycle
//  rf_we       out  1                  write enable to register file
//  rf_wr_addr  out  ADDR_W             head entry address
//  rf_wr_data  out  DATA_W             head entry data
//  rd_addr1    in   ADDR_W             read port 1 address (same as RF rd_addr1)
//  rd_addr2    in   ADDR_W             read port 2 address
//  fwd_hit1    out  1                  pending entry matches rd_addr1
//  fwd_data1   out  DATA_W             youngest pending value for rd_addr1 (0 if no hit)
//  fwd_hit2    out  1                  pending entry matches rd_addr2
//  fwd_data2   out  DATA_W             youngest pending value for rd_addr2 (0 if no hit)
//  count       out  $clog2(DEPTH)+1    pending entries
//  empty       out  1                  count==0
//  full        out  1                  count==DEPTH
// BEHAVIOUR
//  - Reset (rst_n low, async): pointers=0, count=0, entries invalid. Outputs: empty=1,
//    full=0, rf_we=0, in_ready=1, fwd_hit*=0.
//  - pop  = rf_we = !empty && !rf_hold && !flush.
//  - rf_wr_addr/rf_wr_data show the head entry whenever !empty; both are 0 when empty.
//  - push = in_valid && in_ready.
//  - in_ready = !flush && (!full || pop). This is a combinational path from rf_hold.
//  - Push is accepted on a clk edge; that entry is visible to forwarding and rf_we from the
//    next cycle. There is no same-cycle bypass of in_data.
//  - Pop: the register file captures the head at the same edge the queue frees it.
//    Read latency through the queue is therefore >=1 cycle. Order is strictly FIFO.
//  - Simultaneous push+pop: count is unchanged. This is legal when full.
//  - Pointer wrap: pointers are modulo DEPTH.
//  - count arithmetic: +1 on push only, -1 on pop only, never overflows or underflows.
//  - Forwarding (combinational): among valid entries with addr==rd_addrN, pick the youngest
//    (closest to tail).
//    - Multiple writes to one register are not coalesced; all drain in order.
//    - The entry being popped this cycle still forwards. The RF updates only at the edge.
//  - flush: at the next edge count=0, pointers=0, all entries invalid. flush has priority
//    over push and pop. Nothing is written to the RF in a flush cycle.
//  - No state machine beyond FIFO occupancy. States are EMPTY / PARTIAL / FULL, derived
//    from count.
//  - Async reset mid-drain: rf_we drops immediately and pending writes are lost.
// TESTING
//  1. Reset, then push (1,0x55), (2,0xCC) on consecutive cycles with rf_hold=0
//     -> rf_we pulses with addr 1/0x55, then 2/0xCC; RF reads them back; empty=1 afterwards.
//  2. rf_hold=1, push 4 entries -> full=1, in_ready=0. A 5th push is not accepted.
//     Release hold -> 4 writes in order, one per cycle.
//  3. Pending (3,0x11) then (3,0x22), rd_addr1=3 -> fwd_hit1=1, fwd_data1=0x22.
//     After both drain -> fwd_hit1=0 and the RF reads 0x22.
//  4. Full with rf_hold=0 and in_valid=1 -> push and pop in the same cycle, count stays 4;
//     10+ cycles of streaming wrap the pointers with data order preserved.
//  5. 3 pending entries, assert flush 1 cycle -> no rf_we that cycle; count=0 next cycle;
//     RF contents unchanged.
//  6. rst_n low mid-drain (async, between edges) -> rf_we=0 and empty=1 immediately;
//     in_valid pushes resume after release.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back FIFO draining into the register file write port
// Buffers execute results, writes the head each unheld cycle, and forwards pending values to readers.
module regfile_wb_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     flush,
    input  logic                     rf_hold,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_wr_addr,
    output logic [DATA_W-1:0]        rf_wr_data,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic                     fwd_hit1,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  fwd_idx;
    logic              push, pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign count      = count_q;
    assign pop        = !empty && !rf_hold && !flush;
    assign in_ready   = !flush && (!full || pop);
    assign push       = in_valid && in_ready;
    assign rf_we      = pop;
    assign rf_wr_addr = empty ? '0 : addr_q[head_q];
    assign rf_wr_data = empty ? '0 : data_q[head_q];

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pop before push so a full-queue push+pop on the same slot leaves it valid.
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_W'(1);
            end
            if (push) begin
                addr_d[tail_q]  = in_addr;
                data_d[tail_q]  = in_data;
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == rd_addr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_q[fwd_idx];
            end
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == rd_addr2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
